uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

APB master that configures the UART slave after reset and then shares its transmit path among NUM_REQ byte-stream requesters. It arbitrates round-robin with packet locking, polls the UART TX status register for FIFO space, and writes each granted byte to the TX data register. It sits between on-chip byte producers and the UART's APB port, as the only APB master that touches the UART.

## Interface

**Parameters**
- NUM_REQ, 4: number of requesters, range 2–8.
- BASE_ADDR, 32'h1000_0000: UART register base.
- CLK_DIV_INIT, 32'h00D0_0005: value written to the clock-divider register at BASE_ADDR+0x04.
- CONTROL_INIT, 32'h0000_0001: value written to the control register at BASE_ADDR+0x00 (TX enable).
- POLL_LIMIT, 1024: maximum consecutive "FIFO full" polls before the byte is dropped; 16-bit counter.

**Ports**
- PCLK, in, 1: clock.
- PRESETn, in, 1: reset, asynchronous, active-low.
- req_valid, in, NUM_REQ: byte available, one bit per requester.
- req_data, in, 8*NUM_REQ: byte for requester i, in bits [8i+7:8i].
- req_last, in, NUM_REQ: byte ends a packet; releases the lock.
- req_ready, out, NUM_REQ: one-hot, one-cycle accept strobe.
- m_paddr, out, 32: APB address.
- m_psel, out, 1: APB select.
- m_penable, out, 1: APB enable.
- m_pwrite, out, 1: APB write.
- m_pwdata, out, 32: APB write data.
- m_prdata, in, 32: APB read data, valid in the ACCESS cycle.
- init_done, out, 1: configuration writes complete.
- grant_id, out, $clog2(NUM_REQ): requester of the byte in flight.
- busy, out, 1: high in every state except IDLE.
- err_timeout, out, 1: sticky; set when a byte is dropped after POLL_LIMIT full polls.

## Operation

**APB transfers**
- The slave has no PREADY, so every transfer takes exactly 2 cycles.
- SETUP cycle: psel=1, penable=0.
- ACCESS cycle: psel=1, penable=1.
- Outside a transfer, psel, penable, pwrite, paddr and pwdata are all 0.

**FSM states**
- DIV_S → DIV_A: write CLK_DIV_INIT to BASE_ADDR+0x04.
- CTL_S → CTL_A: write CONTROL_INIT to BASE_ADDR+0x00. Then go to IDLE and set init_done=1.
- IDLE:
  - If lock=1 and req_valid[owner]=1: accept from the owner.
  - If lock=1 and the owner is not valid: wait; other requesters are not served.
  - If lock=0: search round-robin starting at ptr+1 modulo NUM_REQ, and accept the first valid requester.
  - On accept: pulse req_ready[g] for one cycle, latch req_data[g] into a holding register, set grant_id=g and ptr=g, set lock=~req_last[g] with owner=g, clear poll_cnt, go to POLL_S.
- POLL_S → POLL_A: read BASE_ADDR+0x40 (TX status).
  - In POLL_A, if m_prdata[9]=0 (not full): go to WR_S.
  - Otherwise increment poll_cnt. If poll_cnt reaches POLL_LIMIT: set err_timeout, discard the byte, go to IDLE. Else return to POLL_S.
- WR_S → WR_A: write {24'b0, byte} to BASE_ADDR+0x80, then go to IDLE.

**Boundary conditions**
- All requesters valid simultaneously with ptr=NUM_REQ-1: requester 0 wins, then 1, 2, … in order.
- Search wrap-around is modulo NUM_REQ.
- A dropped byte still counts as accepted. The lock update from its req_last still applies.
- The accept decision is made only in IDLE. Requests that arrive or change during other states are ignored until IDLE.
- err_timeout clears only on reset.

## Timing

**Reset values**
- state=DIV_S, all APB outputs 0, req_ready=0, init_done=0, grant_id=0, busy=1, err_timeout=0, lock=0, ptr=NUM_REQ-1.
- Asynchronous reset mid-transfer drops psel immediately and restarts the configuration sequence. Any held byte is lost.

**Initialization**
- DIV_S in the first cycle after reset release; CTL_A in cycle 4; IDLE and init_done=1 from cycle 5.

**Per-byte latency**
- Accept in cycle T (req_ready=1).
- POLL_S at T+1, POLL_A at T+2, WR_S at T+3, WR_A at T+4, IDLE at T+5.
- Best-case throughput is 1 byte per 5 cycles.
- Each full poll adds 2 cycles.

## Test plan

- **Init sequence:** release reset → writes of 0x00D0_0005 to 0x1000_0004 (cycles 1–2) and 0x1 to 0x1000_0000 (cycles 3–4); init_done=1 at cycle 5.
- **Single byte:** req_valid[2]=1, data 0x5A, last=1, m_prdata=0 → req_ready=4'b0100 for one cycle; read of 0x1000_0040; write of 0x0000_005A to 0x1000_0080; 5 cycles total.
- **Round-robin:** all four requesters valid with last=1 continuously → grants 0,1,2,3,0 and accept strobes exactly 5 cycles apart.
- **Packet lock:** req 1 sends 3 bytes (last on the third) while req 0 and req 3 are valid → grants 1,1,1, then 3, then 0. A req 1 valid gap during the packet stalls in IDLE with no other grant.
- **Backpressure:** m_prdata[9]=1 for 3 polls then 0 → 4 reads precede the write; accept-to-IDLE takes 11 cycles.
- **Timeout and reset:**
  - POLL_LIMIT=4 with status stuck full → 4 reads, no write, err_timeout=1, next requester served.
  - Assert PRESETn low during WR_A → psel=0 immediately, err_timeout=0, init sequence restarts.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// APB master that configures the UART after reset, then funnels bytes from NUM_REQ
// requesters (round-robin, packet-locked) into the UART TX data register.
module uart_tx_scheduler #(
   parameter int          NUM_REQ      = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter logic [31:0] CLK_DIV_INIT = 32'h00D0_0005,
   parameter logic [31:0] CONTROL_INIT = 32'h0000_0001,
   parameter int          POLL_LIMIT   = 1024
) (
   input  logic                         PCLK,
   input  logic                         PRESETn,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [8*NUM_REQ-1:0]         req_data,
   input  logic [NUM_REQ-1:0]           req_last,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [31:0]                  m_paddr,
   output logic                         m_psel,
   output logic                         m_penable,
   output logic                         m_pwrite,
   output logic [31:0]                  m_pwdata,
   input  logic [31:0]                  m_prdata,
   output logic                         init_done,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         err_timeout
);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [3:0] {
      DIV_S, DIV_A, CTL_S, CTL_A, IDLE, POLL_S, POLL_A, WR_S, WR_A
   } state_t;

   state_t        state, state_nx;
   logic          run;
   logic [IW-1:0] ptr, pick, cand;
   logic          lock, found, accept, poll_hit, tx_full;
   logic [7:0]    hold;
   logic [15:0]   poll_cnt;

   // run holds the bus quiet for the reset cycle so reset drops psel at once.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      cand  = ptr;
      if (lock) begin
         found = req_valid[ptr];
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
               found = 1'b1;
               pick  = cand;
            end
         end
      end
   end

   assign accept    = (state == IDLE) && found;
   assign req_ready = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick) : '0;
   assign tx_full   = m_prdata[9];
   assign poll_hit  = (poll_cnt == 16'(POLL_LIMIT - 1));
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         DIV_S:   state_nx = run ? DIV_A : DIV_S;
         DIV_A:   state_nx = CTL_S;
         CTL_S:   state_nx = CTL_A;
         CTL_A:   state_nx = IDLE;
         IDLE:    state_nx = accept ? POLL_S : IDLE;
         POLL_S:  state_nx = POLL_A;
         POLL_A:  state_nx = !tx_full ? WR_S : (poll_hit ? IDLE : POLL_S);
         WR_S:    state_nx = WR_A;
         WR_A:    state_nx = IDLE;
         default: state_nx = DIV_S;
      endcase
   end

   always_comb begin
      m_psel    = 1'b0;
      m_penable = 1'b0;
      m_pwrite  = 1'b0;
      m_paddr   = '0;
      m_pwdata  = '0;
      if (run) begin
         case (state)
            DIV_S, DIV_A: begin
               m_psel    = 1'b1;
               m_penable = (state == DIV_A);
               m_pwrite  = 1'b1;
               m_paddr   = BASE_ADDR + 32'h04;
               m_pwdata  = CLK_DIV_INIT;
            end
            CTL_S, CTL_A: begin
               m_psel    = 1'b1;
               m_penable = (state == CTL_A);
               m_pwrite  = 1'b1;
               m_paddr   = BASE_ADDR;
               m_pwdata  = CONTROL_INIT;
            end
            POLL_S, POLL_A: begin
               m_psel    = 1'b1;
               m_penable = (state == POLL_A);
               m_paddr   = BASE_ADDR + 32'h40;
            end
            WR_S, WR_A: begin
               m_psel    = 1'b1;
               m_penable = (state == WR_A);
               m_pwrite  = 1'b1;
               m_paddr   = BASE_ADDR + 32'h80;
               m_pwdata  = {24'b0, hold};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= DIV_S;
         run         <= 1'b0;
         init_done   <= 1'b0;
         ptr         <= IW'(NUM_REQ - 1);
         lock        <= 1'b0;
         grant_id    <= '0;
         hold        <= '0;
         poll_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= state_nx;
         if (state == CTL_A) init_done <= 1'b1;
         if (accept) begin
            hold     <= req_data[{pick, 3'b000} +: 8];
            grant_id <= pick;
            ptr      <= pick;
            lock     <= ~req_last[pick];
            poll_cnt <= '0;
         end
         // A dropped byte leaves the lock as set by its own req_last.
         if (state == POLL_A && tx_full) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_hit) err_timeout <= 1'b1;
         end
      end
   end
endmodule
